// File: rtl/instruction_fetch_sequencer_pkg.sv
// Shared types and ARF/memory control encodings for the instruction fetch sequencer.
package fetch_seq_pkg;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_FETCH_LO,
    ST_FETCH_HI,
    ST_ISSUE,
    ST_HALTED
  } fetch_state_e;

  localparam logic [2:0] ARF_FS_INC  = 3'b001;
  localparam logic [2:0] ARF_FS_CLR  = 3'b011;
  localparam logic [2:0] ARF_RS_PC   = 3'b100;
  localparam logic [2:0] ARF_RS_NONE = 3'b000;
  localparam logic [1:0] ARF_OD_PC   = 2'b00;
  localparam logic       MEM_CS_ON   = 1'b0;

endpackage

// File: rtl/instruction_fetch_sequencer_if.sv
// Handshake and datapath control bundle between the fetch sequencer and the
// rest of the ALU system (execute controller, memory, IR, ARF).
interface instruction_fetch_sequencer_if;
  logic       Start;
  logic       Halt;
  logic       ExecDone;
  logic       InstrValid;
  logic       FetchOwnsBus;
  logic       Mem_CS;
  logic       Mem_WR;
  logic       IR_Write;
  logic       IR_LH;
  logic [2:0] ARF_FunSel;
  logic [2:0] ARF_RegSel;
  logic [1:0] ARF_OutDSel;
  logic       Busy;

  // Sequencer side
  modport master (
    input  Start, Halt, ExecDone,
    output InstrValid, FetchOwnsBus, Mem_CS, Mem_WR, IR_Write, IR_LH,
           ARF_FunSel, ARF_RegSel, ARF_OutDSel, Busy
  );

  // System / execute-controller side
  modport slave (
    output Start, Halt, ExecDone,
    input  InstrValid, FetchOwnsBus, Mem_CS, Mem_WR, IR_Write, IR_LH,
           ARF_FunSel, ARF_RegSel, ARF_OutDSel, Busy
  );
endinterface

// File: rtl/instruction_fetch_sequencer_fetch_counter.sv
// 16-bit wrapping counter with synchronous clear (priority) and enable.
module fetch_counter (
  input  logic        clk_i,
  input  logic        clr_i,
  input  logic        en_i,
  output logic [15:0] count_o
);
  logic [15:0] count_q;

  // Clear wins over enable; natural 16-bit wrap on increment
  always_ff @(posedge clk_i) begin
    if (clr_i)     count_q <= '0;
    else if (en_i) count_q <= count_q + 16'd1;
  end

  assign count_o = count_q;
endmodule

// File: rtl/instruction_fetch_sequencer.sv
// Fetch-side control FSM: reads a 16-bit instruction (low byte, then high byte)
// at the PC into the IR, bumping the PC per byte, then hands it to the execute
// controller via InstrValid/ExecDone. Optional FETCH_COUNT_EN adds a 16-bit
// FetchCount output counting completed fetches.
module instruction_fetch_sequencer
  import fetch_seq_pkg::*;
#(
  parameter int unsigned RESET_PC_CLEAR = 1
) (
  input  logic                           Clock,
  input  logic                           Reset,
  instruction_fetch_sequencer_if.master  bus
`ifdef FETCH_COUNT_EN
  ,
  output logic [15:0]                    FetchCount
`endif
);

  fetch_state_e state_q, state_d;

  // State register; reset forces INIT from any state
  always_ff @(posedge Clock) begin
    if (Reset) state_q <= ST_INIT;
    else       state_q <= state_d;
  end

  // Next-state and Moore output decode
  always_comb begin
    state_d          = state_q;
    bus.InstrValid   = 1'b0;
    bus.FetchOwnsBus = 1'b0;
    bus.Mem_CS       = ~MEM_CS_ON;
    bus.Mem_WR       = 1'b0;
    bus.IR_Write     = 1'b0;
    bus.IR_LH        = 1'b0;
    bus.ARF_FunSel   = 3'b000;
    bus.ARF_RegSel   = ARF_RS_NONE;
    bus.ARF_OutDSel  = ARF_OD_PC;
    bus.Busy         = 1'b1;

    unique case (state_q)
      ST_INIT: begin
        bus.FetchOwnsBus = 1'b1;
        if (RESET_PC_CLEAR != 0) begin
          bus.ARF_RegSel = ARF_RS_PC;
          bus.ARF_FunSel = ARF_FS_CLR;
        end
        state_d = ST_IDLE;
      end
      ST_IDLE: begin
        bus.Busy = 1'b0;
        if (bus.Start) state_d = ST_FETCH_LO;
      end
      ST_FETCH_LO, ST_FETCH_HI: begin
        bus.FetchOwnsBus = 1'b1;
        bus.Mem_CS       = MEM_CS_ON;
        bus.IR_Write     = 1'b1;
        bus.IR_LH        = (state_q == ST_FETCH_HI);
        bus.ARF_RegSel   = ARF_RS_PC;
        bus.ARF_FunSel   = ARF_FS_INC;
        state_d          = (state_q == ST_FETCH_LO) ? ST_FETCH_HI : ST_ISSUE;
      end
      ST_ISSUE: begin
        bus.InstrValid = 1'b1;
        if (bus.ExecDone) state_d = bus.Halt ? ST_HALTED : ST_FETCH_LO;
      end
      ST_HALTED: begin
        bus.Busy = 1'b0;
        if (bus.Start) state_d = ST_FETCH_LO;
      end
      default: state_d = ST_INIT;
    endcase
  end

`ifdef FETCH_COUNT_EN
  // Reset gates the enable so an aborted FETCH_HI is not counted
  fetch_counter u_fetch_counter (
    .clk_i   (Clock),
    .clr_i   (Reset || (state_q == ST_INIT)),
    .en_i    (!Reset && (state_q == ST_FETCH_HI)),
    .count_o (FetchCount)
  );
`endif

endmodule
